// File: rtl/median_pkg.sv
// median_pkg: shared types, default sizes and window-length legality check for median_stream_filter.
package median_pkg;
   localparam int DATA_W_DEF = 32;
   localparam int WIN_DEF    = 9;
   localparam int MED_IDX    = WIN_DEF / 2;
   typedef logic [DATA_W_DEF-1:0] data_t;
   function automatic bit win_ok(input int win);
      return (win >= 3) && (win <= 31) && (win % 2 == 1);
   endfunction
endpackage

// File: rtl/median_cas.sv
// median_cas: compare-and-swap of two samples into lo/hi.
// MEDIAN_SIGNED_EN selects a two's complement compare; otherwise unsigned.
module median_cas
   import median_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic [DATA_W-1:0] a_i,
   input  logic [DATA_W-1:0] b_i,
   output logic [DATA_W-1:0] lo_o,
   output logic [DATA_W-1:0] hi_o
);
   logic swap;
`ifdef MEDIAN_SIGNED_EN
   assign swap = $signed(a_i) > $signed(b_i);
`else
   assign swap = a_i > b_i;
`endif
   assign lo_o = swap ? b_i : a_i;
   assign hi_o = swap ? a_i : b_i;
endmodule

// File: rtl/median_stream_filter.sv
// median_stream_filter: sliding-window median/min/max through a registered odd-even transposition sort.
// MEDIAN_SIGNED_EN (tested inside median_cas) switches every compare to signed samples.
module median_stream_filter
   import median_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int WIN    = WIN_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_median,
   output logic [DATA_W-1:0] out_min,
   output logic [DATA_W-1:0] out_max
);
   localparam int MID = WIN / 2;
   localparam int FW  = $clog2(WIN + 1);
   typedef logic [DATA_W-1:0] word_t;

   if (!win_ok(WIN)) begin : g_bad_win
      $error("median_stream_filter: WIN=%0d must be odd and within 3..31", WIN);
   end

   word_t          win_q   [WIN];
   word_t          win_d   [WIN];
   word_t          stg_q   [WIN][WIN];
   word_t          stg_d   [WIN][WIN];
   word_t          lay_in  [WIN][WIN];
   word_t          lay_out [WIN][WIN];
   logic [WIN-1:0] vld_q, vld_d;
   logic           issue_q, issue_d;
   logic [FW-1:0]  fill_q, fill_d;
   logic           advance, accept;

   assign advance    = !vld_q[WIN-1] || out_ready;
   assign in_ready   = advance && !clear;
   assign accept     = in_valid && in_ready;
   assign out_valid  = vld_q[WIN-1];
   assign out_median = stg_q[WIN-1][MID];
   assign out_min    = stg_q[WIN-1][0];
   assign out_max    = stg_q[WIN-1][WIN-1];

   // layer i pairs (j, j+1) with j of the same parity as i; unpaired edge slots pass straight through
   for (genvar i = 0; i < WIN; i++) begin : g_layer
      if (i == 0) begin : g_src_win
         assign lay_in[i] = win_q;
      end else begin : g_src_stg
         assign lay_in[i] = stg_q[i-1];
      end
      for (genvar j = 0; j < WIN; j++) begin : g_slot
         if ((j % 2) == (i % 2) && j + 1 < WIN) begin : g_cas
            median_cas #(.DATA_W(DATA_W)) u_cas (
               .a_i  (lay_in[i][j]),
               .b_i  (lay_in[i][j+1]),
               .lo_o (lay_out[i][j]),
               .hi_o (lay_out[i][j+1])
            );
         end else if (((j % 2) == (i % 2)) ? (j + 1 >= WIN) : (j == 0)) begin : g_pass
            assign lay_out[i][j] = lay_in[i][j];
         end
      end
   end

   always_comb begin
      win_d   = win_q;
      stg_d   = stg_q;
      vld_d   = vld_q;
      issue_d = issue_q;
      fill_d  = fill_q;
      if (advance) begin
         stg_d   = lay_out;
         vld_d   = {vld_q[WIN-2:0], issue_q};
         issue_d = accept && (fill_q >= FW'(WIN - 1));
      end
      if (accept) begin
         win_d[0] = in_data;
         for (int k = 1; k < WIN; k++) win_d[k] = win_q[k-1];
         fill_d = (fill_q == FW'(WIN)) ? fill_q : fill_q + FW'(1);
      end
      // stale window data is harmless once fill restarts from zero
      if (clear) begin
         fill_d  = '0;
         vld_d   = '0;
         issue_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         win_q   <= '{default: '0};
         stg_q   <= '{default: '{default: '0}};
         vld_q   <= '0;
         issue_q <= 1'b0;
         fill_q  <= '0;
      end else begin
         win_q   <= win_d;
         stg_q   <= stg_d;
         vld_q   <= vld_d;
         issue_q <= issue_d;
         fill_q  <= fill_d;
      end
   end
endmodule

// File: tb/tb_median_stream_filter.sv
// tb_median_stream_filter: randomized scenarios on a WIN=5 instance against a sort-based window model,
// plus a WIN=3 8-bit instance for the signed/unsigned ordering case.
module tb_median_stream_filter;
   localparam int DW = 16;
   localparam int WN = 5;
`ifdef MEDIAN_SIGNED_EN
   localparam logic [7:0] S_MED = 8'h01, S_MIN = 8'h80, S_MAX = 8'h7F;
`else
   localparam logic [7:0] S_MED = 8'h7F, S_MIN = 8'h01, S_MAX = 8'h80;
`endif
   typedef logic [DW-1:0] word_t;
   typedef struct { word_t med; word_t mn; word_t mx; int cyc; bit ok; } res_t;

   logic       clk = 1'b0, rst = 1'b1, clear = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
   word_t      in_data = '0;
   logic       in_ready, out_valid;
   word_t      out_median, out_min, out_max;
   logic       in_valid3 = 1'b0;
   logic [7:0] in_data3 = '0;
   logic       in_ready3, out_valid3;
   logic [7:0] med3, min3, max3;
   int         total = 0, bad = 0, cyc = 0;
   res_t       got[$], expd[$], pend[$];
   word_t      mwin[$];
   int         acc_cyc[$];
   res_t       mon_r, mon_e;

   median_stream_filter #(.DATA_W(DW), .WIN(WN)) u_dut (
      .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_median(out_median), .out_min(out_min), .out_max(out_max)
   );
   median_stream_filter #(.DATA_W(8), .WIN(3)) u_dut3 (
      .clk(clk), .rst(rst), .clear(1'b0), .in_valid(in_valid3), .in_ready(in_ready3), .in_data(in_data3),
      .out_valid(out_valid3), .out_ready(1'b1), .out_median(med3), .out_min(min3), .out_max(max3)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within the time limit");
      $fatal(1, "watchdog expired");
   end

   function automatic word_t key(input word_t x);
`ifdef MEDIAN_SIGNED_EN
      return x ^ {1'b1, {(DW-1){1'b0}}};
`else
      return x;
`endif
   endfunction

   function automatic res_t golden(input word_t w[$]);
      word_t s[$];
      word_t t;
      res_t  r;
      s = w;
      for (int i = 1; i < s.size(); i++)
         for (int j = i; j > 0; j--)
            if (key(s[j-1]) > key(s[j])) begin
               t = s[j]; s[j] = s[j-1]; s[j-1] = t;
            end
      r.med = s[s.size() / 2]; r.mn = s[0]; r.mx = s[s.size() - 1]; r.cyc = 0; r.ok = 1'b1;
      return r;
   endfunction

   // window model: every accept slides the window; each full window owes one result, in order
   always @(negedge clk) begin
      if (out_valid && out_ready) begin
         mon_r = '{med: out_median, mn: out_min, mx: out_max, cyc: cyc, ok: 1'b1};
         mon_e = '{med: '0, mn: '0, mx: '0, cyc: 0, ok: 1'b0};
         if (pend.size() > 0) mon_e = pend.pop_front();
         got.push_back(mon_r);
         expd.push_back(mon_e);
      end
      if (in_valid && in_ready) begin
         acc_cyc.push_back(cyc);
         mwin.push_back(in_data);
         if (mwin.size() > WN) void'(mwin.pop_front());
         if (mwin.size() == WN) pend.push_back(golden(mwin));
      end
      if (rst || clear) begin
         mwin.delete();
         pend.delete();
      end
   end

   task automatic feed(input word_t v, inout bit ok);
      int n;
      n = 0;
      in_valid = 1'b1;
      in_data  = v;
      @(negedge clk);
      while (!in_ready && n < 50) begin
         n++;
         @(negedge clk);
      end
      if (!in_ready) ok = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got=%0b want=0", out_valid); end
      total++; if (out_median !== '0) begin bad++; $display("FAIL reset_median: got=%0h want=0", out_median); end
      total++; if (out_min !== '0) begin bad++; $display("FAIL reset_min: got=%0h want=0", out_min); end
      total++; if (out_max !== '0) begin bad++; $display("FAIL reset_max: got=%0h want=0", out_max); end
      total++; if (out_valid3 !== 1'b0) begin bad++; $display("FAIL reset_out_valid3: got=%0b want=0", out_valid3); end
      rst = 1'b0;
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got=%0b want=1", in_ready); end
      total++; if (in_ready3 !== 1'b1) begin bad++; $display("FAIL reset_in_ready3: got=%0b want=1", in_ready3); end
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      bit    ok;
      word_t seq[6];
      seq = '{16'd5, 16'd1, 16'd4, 16'd2, 16'd3, 16'd9};
      ok = 1'b1;
      got.delete(); expd.delete(); acc_cyc.delete();
      foreach (seq[k]) feed(seq[k], ok);
      idle(10);
      total++; if (!ok) begin bad++; $display("FAIL basic_accept: got=stalled want=accepted"); end
      total++; if (got.size() != 2) begin bad++; $display("FAIL basic_count: got=%0d want=2", got.size()); end
      if (got.size() == 2 && acc_cyc.size() == 6) begin
         total++; if (got[0].med !== 16'd3) begin bad++; $display("FAIL basic_median0: got=%0d want=3", got[0].med); end
         total++; if (got[0].mn !== 16'd1) begin bad++; $display("FAIL basic_min0: got=%0d want=1", got[0].mn); end
         total++; if (got[0].mx !== 16'd5) begin bad++; $display("FAIL basic_max0: got=%0d want=5", got[0].mx); end
         total++; if (got[1].med !== 16'd3) begin bad++; $display("FAIL basic_median1: got=%0d want=3", got[1].med); end
         total++; if (got[1].mn !== 16'd1) begin bad++; $display("FAIL basic_min1: got=%0d want=1", got[1].mn); end
         total++; if (got[1].mx !== 16'd9) begin bad++; $display("FAIL basic_max1: got=%0d want=9", got[1].mx); end
         total++; if (got[0].cyc - acc_cyc[4] != WN + 1) begin bad++; $display("FAIL basic_latency: got=%0d want=%0d", got[0].cyc - acc_cyc[4], WN + 1); end
         total++; if (got[1].cyc - got[0].cyc != 1) begin bad++; $display("FAIL basic_spacing: got=%0d want=1", got[1].cyc - got[0].cyc); end
      end
   endtask

   task automatic test_signed();
      logic [7:0] s3[3];
      int         n;
      bit         seen;
      s3 = '{8'h80, 8'h01, 8'h7F};
      for (int k = 0; k < 3; k++) begin
         in_valid3 = 1'b1;
         in_data3  = s3[k];
         @(negedge clk);
         total++; if (in_ready3 !== 1'b1) begin bad++; $display("FAIL signed_in_ready: got=%0b want=1", in_ready3); end
         @(posedge clk); #1;
      end
      in_valid3 = 1'b0;
      n = 0;
      seen = 1'b0;
      while (!seen && n < 20) begin
         @(negedge clk);
         seen = out_valid3;
         n++;
      end
      total++;
      if (!seen) begin
         bad++; $display("FAIL signed_timeout: got=no result want=result");
      end else begin
         total++; if (n != 4) begin bad++; $display("FAIL signed_latency: got=%0d want=4", n); end
         total++; if (med3 !== S_MED) begin bad++; $display("FAIL signed_median: got=%0h want=%0h", med3, S_MED); end
         total++; if (min3 !== S_MIN) begin bad++; $display("FAIL signed_min: got=%0h want=%0h", min3, S_MIN); end
         total++; if (max3 !== S_MAX) begin bad++; $display("FAIL signed_max: got=%0h want=%0h", max3, S_MAX); end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      bit ok;
      ok = 1'b1;
      got.delete(); expd.delete(); acc_cyc.delete();
      for (int k = 0; k < 30; k++) feed(word_t'($urandom), ok);
      idle(10);
      total++; if (!ok) begin bad++; $display("FAIL b2b_accept: got=stalled want=accepted"); end
      total++; if (got.size() != 30) begin bad++; $display("FAIL b2b_count: got=%0d want=30", got.size()); end
      for (int i = 0; i < got.size(); i++) begin
         total++;
         if (!expd[i].ok || got[i].med !== expd[i].med || got[i].mn !== expd[i].mn || got[i].mx !== expd[i].mx) begin
            bad++; $display("FAIL b2b_result[%0d]: got=%0h/%0h/%0h want=%0h/%0h/%0h", i, got[i].med, got[i].mn, got[i].mx, expd[i].med, expd[i].mn, expd[i].mx);
         end
         if (i > 0) begin
            total++; if (got[i].cyc - got[i-1].cyc != 1) begin bad++; $display("FAIL b2b_spacing[%0d]: got=%0d want=1", i, got[i].cyc - got[i-1].cyc); end
         end
      end
   endtask

   task automatic test_backpressure();
      word_t smp[24];
      int    idx;
      foreach (smp[k]) smp[k] = word_t'($urandom);
      idx = 0;
      got.delete(); expd.delete(); acc_cyc.delete();
      for (int c = 0; c < 30; c++) begin
         in_valid  = idx < 24;
         if (idx < 24) in_data = smp[idx];
         out_ready = !(c >= 12 && c < 16);
         @(negedge clk);
         if (c == 12) begin
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_out_valid: got=%0b want=1", out_valid); end
         end
         if (c >= 12 && c < 16) begin
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready[%0d]: got=%0b want=0", c, in_ready); end
            if (pend.size() > 0) begin
               total++;
               if (out_median !== pend[0].med || out_min !== pend[0].mn || out_max !== pend[0].mx) begin
                  bad++; $display("FAIL bp_hold[%0d]: got=%0h/%0h/%0h want=%0h/%0h/%0h", c, out_median, out_min, out_max, pend[0].med, pend[0].mn, pend[0].mx);
               end
            end
         end
         if (in_valid && in_ready) idx++;
         @(posedge clk); #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      idle(12);
      total++; if (idx != 24) begin bad++; $display("FAIL bp_accepted: got=%0d want=24", idx); end
      total++; if (got.size() != 24) begin bad++; $display("FAIL bp_count: got=%0d want=24", got.size()); end
      total++; if (pend.size() != 0) begin bad++; $display("FAIL bp_pending: got=%0d want=0", pend.size()); end
      for (int i = 0; i < got.size(); i++) begin
         total++;
         if (!expd[i].ok || got[i].med !== expd[i].med || got[i].mn !== expd[i].mn || got[i].mx !== expd[i].mx) begin
            bad++; $display("FAIL bp_result[%0d]: got=%0h/%0h/%0h want=%0h/%0h/%0h", i, got[i].med, got[i].mn, got[i].mx, expd[i].med, expd[i].mn, expd[i].mx);
         end
      end
   endtask

   task automatic test_clear();
      bit ok;
      ok = 1'b1;
      for (int k = 0; k < 3; k++) feed(word_t'($urandom), ok);
      clear    = 1'b1;
      in_valid = 1'b1;
      in_data  = word_t'($urandom);
      @(negedge clk);
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL clear_in_ready: got=%0b want=0", in_ready); end
      @(posedge clk); #1;
      clear    = 1'b0;
      in_valid = 1'b0;
      got.delete(); expd.delete(); acc_cyc.delete();
      for (int k = 0; k < 4; k++) feed(word_t'($urandom), ok);
      idle(8);
      total++; if (got.size() != 0) begin bad++; $display("FAIL clear_early_output: got=%0d want=0", got.size()); end
      feed(word_t'($urandom), ok);
      idle(8);
      total++; if (!ok) begin bad++; $display("FAIL clear_accept: got=stalled want=accepted"); end
      total++; if (got.size() != 1) begin bad++; $display("FAIL clear_count: got=%0d want=1", got.size()); end
      total++; if (pend.size() != 0) begin bad++; $display("FAIL clear_pending: got=%0d want=0", pend.size()); end
      if (got.size() == 1) begin
         total++;
         if (!expd[0].ok || got[0].med !== expd[0].med || got[0].mn !== expd[0].mn || got[0].mx !== expd[0].mx) begin
            bad++; $display("FAIL clear_result: got=%0h/%0h/%0h want=%0h/%0h/%0h", got[0].med, got[0].mn, got[0].mx, expd[0].med, expd[0].mn, expd[0].mx);
         end
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      ok = 1'b1;
      for (int k = 0; k < 3; k++) feed(word_t'($urandom), ok);
      repeat (3) @(posedge clk);
      #2;
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL rstmid_before: got=%0b want=1", out_valid); end
      #1 rst = 1'b1;
      #1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_out_valid: got=%0b want=0", out_valid); end
      total++; if (out_median !== '0) begin bad++; $display("FAIL rstmid_median: got=%0h want=0", out_median); end
      total++; if (out_min !== '0) begin bad++; $display("FAIL rstmid_min: got=%0h want=0", out_min); end
      total++; if (out_max !== '0) begin bad++; $display("FAIL rstmid_max: got=%0h want=0", out_max); end
      @(negedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #1;
      got.delete(); expd.delete(); acc_cyc.delete();
      for (int k = 0; k < 4; k++) feed(word_t'($urandom), ok);
      idle(8);
      total++; if (got.size() != 0) begin bad++; $display("FAIL rstmid_early_output: got=%0d want=0", got.size()); end
      feed(word_t'($urandom), ok);
      idle(8);
      total++; if (!ok) begin bad++; $display("FAIL rstmid_accept: got=stalled want=accepted"); end
      total++; if (got.size() != 1) begin bad++; $display("FAIL rstmid_count: got=%0d want=1", got.size()); end
      if (got.size() == 1) begin
         total++;
         if (!expd[0].ok || got[0].med !== expd[0].med || got[0].mn !== expd[0].mn || got[0].mx !== expd[0].mx) begin
            bad++; $display("FAIL rstmid_result: got=%0h/%0h/%0h want=%0h/%0h/%0h", got[0].med, got[0].mn, got[0].mx, expd[0].med, expd[0].mn, expd[0].mx);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_signed();
      test_back_to_back();
      test_backpressure();
      test_clear();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
